// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: control codes,
// instruction class encodings, FSM states and the base-op decode helper.
package alu_ctrl_pkg;

    localparam int CODE_W = 5;
    typedef logic [CODE_W-1:0] ctrl_code_t;

    localparam ctrl_code_t C_ADD    = 5'b00000;
    localparam ctrl_code_t C_SUB    = 5'b00001;
    localparam ctrl_code_t C_XOR    = 5'b00010;
    localparam ctrl_code_t C_OR     = 5'b00011;
    localparam ctrl_code_t C_AND    = 5'b00100;
    localparam ctrl_code_t C_SLL    = 5'b00101;
    localparam ctrl_code_t C_SRL    = 5'b00110;
    localparam ctrl_code_t C_SRA    = 5'b00111;
    localparam ctrl_code_t C_SLT    = 5'b01000;
    localparam ctrl_code_t C_SLTU   = 5'b01001;
    localparam ctrl_code_t C_MUL    = 5'b10000;
    localparam ctrl_code_t C_MULH   = 5'b10001;
    localparam ctrl_code_t C_MULHSU = 5'b10010;
    localparam ctrl_code_t C_MULHU  = 5'b10011;
    localparam ctrl_code_t C_DIV    = 5'b10100;
    localparam ctrl_code_t C_DIVU   = 5'b10101;
    localparam ctrl_code_t C_REM    = 5'b10110;
    localparam ctrl_code_t C_REMU   = 5'b10111;

    typedef enum logic [2:0] {
        OP_R      = 3'b000,
        OP_I      = 3'b001,
        OP_LOAD   = 3'b010,
        OP_STORE  = 3'b011,
        OP_BRANCH = 3'b100,
        OP_JUMP   = 3'b101
    } alu_op_t;

    localparam logic [6:0] FN7_BASE = 7'b0000000;
    localparam logic [6:0] FN7_ALT  = 7'b0100000;
    localparam logic [6:0] FN7_M    = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // RISC-V funct3 to base integer op (the fn7=0000000 meaning).
    function automatic ctrl_code_t base_code(input logic [2:0] fn3);
        case (fn3)
            3'b000:  return C_ADD;
            3'b001:  return C_SLL;
            3'b010:  return C_SLT;
            3'b011:  return C_SLTU;
            3'b100:  return C_XOR;
            3'b101:  return C_SRL;
            3'b110:  return C_OR;
            default: return C_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// Request/response bundle between the pipeline and the ALU control sequencer.
//
// Handshake: a request transfers on a rising clk edge where in_valid=1,
// in_ready=1 and flush=0. in_ready does not depend on in_valid. Results are
// not back-pressured: out_valid is a one-cycle pulse and control_out/illegal
// stay stable until the next transfer.
interface alu_control_seq_if #(
    parameter int CTRL_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        alu_op;
    logic [2:0]        fn3;
    logic [6:0]        fn7;
    logic              flush;
    logic [CTRL_W-1:0] control_out;
    logic              m_start;
    logic              stall;
    logic              out_valid;
    logic              illegal;

    modport master (
        output in_valid, alu_op, fn3, fn7, flush,
        input  in_ready, control_out, m_start, stall, out_valid, illegal
    );

    modport slave (
        input  in_valid, alu_op, fn3, fn7, flush,
        output in_ready, control_out, m_start, stall, out_valid, illegal
    );
endinterface

// File: rtl/alu_decode.sv
// Pure combinational decode of instruction class/funct fields into an ALU
// control code, an illegal flag and multiply/divide classification.
module alu_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [2:0] alu_op,
    input  logic [2:0] fn3,
    input  logic [6:0] fn7,
    output ctrl_code_t code,
    output logic       illegal,
    output logic       is_mul,
    output logic       is_div
);

    // Class/funct decode; unsupported encodings fall back to ADD + illegal.
    always_comb begin
        code    = C_ADD;
        illegal = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (alu_op)
            OP_R: begin
                case (fn7)
                    FN7_BASE: code = base_code(fn3);
                    FN7_ALT: begin
                        if (fn3 == 3'b000)      code = C_SUB;
                        else if (fn3 == 3'b101) code = C_SRA;
                        else                    illegal = 1'b1;
                    end
                    FN7_M: begin
                        if (ENABLE_M != 0) begin
                            // M ops are laid out as 10 + funct3.
                            code   = {2'b10, fn3};
                            is_div = fn3[2];
                            is_mul = ~fn3[2];
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_I: begin
                // fn7 is immediate data here; it only matters for the shift-right form.
                if (fn3 == 3'b101 && fn7 == FN7_ALT) code = C_SRA;
                else                                 code = base_code(fn3);
            end
            OP_LOAD, OP_STORE, OP_JUMP: code = C_ADD;
            OP_BRANCH: begin
                case (fn3[2:1])
                    2'b00:   code = C_SUB;
                    2'b10:   code = C_SLT;
                    2'b11:   code = C_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: accepts decode requests, registers the control code,
// and holds the pipeline for the fixed latency of multi-cycle M operations.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W   = 5,
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_control_seq_if.slave     bus,
    output state_t               state_dbg
);

    // Counter sized for the longer latency so a large MUL_LAT with a short
    // DIV_LAT still fits; with the default latencies this is clog2(DIV_LAT+1).
    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_m1;
    ctrl_code_t       dec_code;
    logic             dec_illegal, dec_is_mul, dec_is_div;
    logic             accept;

    alu_decode #(.ENABLE_M(ENABLE_M)) u_decode (
        .alu_op  (bus.alu_op),
        .fn3     (bus.fn3),
        .fn7     (bus.fn7),
        .code    (dec_code),
        .illegal (dec_illegal),
        .is_mul  (dec_is_mul),
        .is_div  (dec_is_div)
    );

    assign accept        = bus.in_valid && (state_q != BUSY) && !bus.flush;
    assign bus.in_ready  = (state_q != BUSY);
    assign bus.stall     = (state_q == BUSY);
    assign bus.out_valid = (state_q == DONE);
    assign state_dbg     = state_q;

    // Remaining BUSY cycles to load for the op being accepted (0 = single cycle).
    always_comb begin
        lat_m1 = '0;
        if (dec_is_mul)      lat_m1 = CNT_W'(MUL_LAT - 1);
        else if (dec_is_div) lat_m1 = CNT_W'(DIV_LAT - 1);
    end

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: flush dominates, DONE allows back-to-back acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (lat_m1 != '0) begin
                            state_d = BUSY;
                            cnt_d   = lat_m1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Result registers load on acceptance; m_start marks the cycle after an M launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.control_out <= '0;
            bus.illegal     <= 1'b0;
            bus.m_start     <= 1'b0;
        end else begin
            bus.m_start <= accept && (dec_is_mul || dec_is_div);
            if (accept) begin
                bus.control_out <= CTRL_W'(dec_code);
                bus.illegal     <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: scoreboard of expected
// {illegal, code} and completion cycle, plus directed timing checks.
module tb_alu_control_seq;
    import alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_control_seq_if #(.CTRL_W(5)) bus ();
    alu_control_seq_if #(.CTRL_W(5)) bus2 ();
    state_t state_dbg, state_dbg2;

    alu_control_seq #(.CTRL_W(5), .ENABLE_M(1), .MUL_LAT(2), .DIV_LAT(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg)
    );

    alu_control_seq #(.CTRL_W(5), .ENABLE_M(0), .MUL_LAT(2), .DIV_LAT(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .state_dbg(state_dbg2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [5:0] exp_q[$];
    int exp_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                logic [5:0] e;
                int c;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("result", {26'd0, bus.illegal, bus.control_out}, {26'd0, e});
                check("latency", cyc, c);
            end
        end
    end

    // Drive one request at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] code, input logic ill, input int lat);
        int guard;
        guard = 0;
        bus.alu_op = op;
        bus.fn3 = f3;
        bus.fn7 = f7;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) begin
            exp_q.push_back({ill, code});
            exp_cyc_q.push_back(cyc + lat);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [5:0] branch_exp(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001: return 6'b0_00001;
            3'b100, 3'b101: return 6'b0_01000;
            3'b110, 3'b111: return 6'b0_01001;
            default:        return 6'b1_00000;
        endcase
    endfunction

    initial begin
        logic [2:0] rf3;
        logic [6:0] rf7;
        logic [2:0] rop;
        logic [5:0] be;
        int t0;
        int guard;

        bus.in_valid = 1'b0; bus.flush = 1'b0;
        bus.alu_op = 3'b000; bus.fn3 = 3'b000; bus.fn7 = 7'd0;
        bus2.in_valid = 1'b0; bus2.flush = 1'b0;
        bus2.alu_op = 3'b000; bus2.fn3 = 3'b000; bus2.fn7 = 7'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_ctrl", 32'(bus.control_out), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        check("rst_m_start", 32'(bus.m_start), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // R-type ADD/SUB/SRA back to back, never stalling
        send(OP_R, 3'b000, 7'h00, C_ADD, 1'b0, 1);
        check("r_add_stall", 32'(bus.stall), 32'd0);
        send(OP_R, 3'b000, 7'h20, C_SUB, 1'b0, 1);
        check("r_sub_stall", 32'(bus.stall), 32'd0);
        send(OP_R, 3'b101, 7'h20, C_SRA, 1'b0, 1);
        check("r_sra_stall", 32'(bus.stall), 32'd0);

        // Assorted single-cycle decodes and illegal encodings
        send(OP_R, 3'b100, 7'h00, C_XOR,  1'b0, 1);
        send(OP_R, 3'b011, 7'h00, C_SLTU, 1'b0, 1);
        send(OP_R, 3'b111, 7'h00, C_AND,  1'b0, 1);
        send(OP_I, 3'b101, 7'h00, C_SRL,  1'b0, 1);
        send(OP_I, 3'b101, 7'h20, C_SRA,  1'b0, 1);
        send(OP_I, 3'b000, 7'h20, C_ADD,  1'b0, 1);
        send(OP_I, 3'b110, 7'h55, C_OR,   1'b0, 1);
        send(OP_R, 3'b001, 7'h20, C_ADD,  1'b1, 1);
        send(OP_R, 3'b000, 7'h7f, C_ADD,  1'b1, 1);
        send(3'b110, 3'b000, 7'h00, C_ADD, 1'b1, 1);
        send(3'b111, 3'b010, 7'h01, C_ADD, 1'b1, 1);

        // Load/store/jump always ADD; branches per funct3
        for (int i = 0; i < 6; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            rf7 = 7'($urandom_range(0, 127));
            case ($urandom_range(0, 2))
                0:       rop = OP_LOAD;
                1:       rop = OP_STORE;
                default: rop = OP_JUMP;
            endcase
            send(rop, rf3, rf7, C_ADD, 1'b0, 1);
        end
        for (int i = 0; i < 8; i++) begin
            rf3 = 3'(i);
            be = branch_exp(rf3);
            send(OP_BRANCH, rf3, 7'($urandom_range(0, 127)), be[4:0], be[5], 1);
        end

        // DIV: full 32-cycle timing
        repeat (2) @(negedge clk);
        t0 = cyc;
        send(OP_R, 3'b100, 7'h01, C_DIV, 1'b0, 32);
        check("div_m_start_first", 32'(bus.m_start), 32'd1);
        check("div_stall_first", 32'(bus.stall), 32'd1);
        check("div_ready_first", 32'(bus.in_ready), 32'd0);
        check("div_state_busy", 32'(state_dbg), 32'(BUSY));
        bus.in_valid = 1'b1;  // ignored while BUSY
        bus.alu_op = OP_R; bus.fn3 = 3'b000; bus.fn7 = 7'h20;
        for (int i = 2; i <= 31; i++) begin
            @(negedge clk);
            check("div_stall", 32'(bus.stall), 32'd1);
            check("div_in_ready", 32'(bus.in_ready), 32'd0);
            check("div_m_start_off", 32'(bus.m_start), 32'd0);
            check("div_no_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("div_valid_cycle", cyc - t0, 32'd32);
        check("div_out_valid", 32'(bus.out_valid), 32'd1);
        check("div_stall_end", 32'(bus.stall), 32'd0);
        @(negedge clk);

        // MUL (latency 2) then back-to-back XOR accepted in DONE
        send(OP_R, 3'b000, 7'h01, C_MUL, 1'b0, 2);
        check("mul_m_start", 32'(bus.m_start), 32'd1);
        send(OP_R, 3'b100, 7'h00, C_XOR, 1'b0, 1);
        send(OP_R, 3'b011, 7'h01, C_MULHU, 1'b0, 2);
        send(OP_R, 3'b110, 7'h01, C_REM, 1'b0, 32);
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end

        // Flush at T+5 of a DIV
        @(negedge clk);
        t0 = cyc;
        bus.alu_op = OP_R; bus.fn3 = 3'b100; bus.fn7 = 7'h01; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("flush_pre_busy", 32'(state_dbg), 32'(BUSY));
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_cycle", cyc - t0, 32'd6);
        check("flush_state", 32'(state_dbg), 32'(IDLE));
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_m_start", 32'(bus.m_start), 32'd0);
        repeat (40) @(negedge clk);

        // Flush beats a simultaneous request
        bus.alu_op = OP_R; bus.fn3 = 3'b000; bus.fn7 = 7'h20;
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        check("flush_win_state", 32'(state_dbg), 32'(IDLE));
        check("flush_win_ctrl", 32'(bus.control_out), 32'(C_DIV));
        repeat (3) @(negedge clk);

        // ENABLE_M=0 instance: legal SUB, then M op and unknown class illegal
        bus2.alu_op = OP_R; bus2.fn3 = 3'b000; bus2.fn7 = 7'h20; bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        check("nom_sub_valid", 32'(bus2.out_valid), 32'd1);
        check("nom_sub_code", {26'd0, bus2.illegal, bus2.control_out}, 32'h01);
        @(negedge clk);
        bus2.alu_op = OP_R; bus2.fn3 = 3'b000; bus2.fn7 = 7'h01; bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        check("nom_m_valid", 32'(bus2.out_valid), 32'd1);
        check("nom_m_code", {26'd0, bus2.illegal, bus2.control_out}, 32'h20);
        check("nom_m_start", 32'(bus2.m_start), 32'd0);
        check("nom_m_stall", 32'(bus2.stall), 32'd0);
        bus2.alu_op = OP_R; bus2.fn3 = 3'b001; bus2.fn7 = 7'h00; bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.alu_op = 3'b111; bus2.fn3 = 3'b000; bus2.fn7 = 7'h00;
        check("nom_sll_code", {26'd0, bus2.illegal, bus2.control_out}, 32'h05);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        check("nom_op7_valid", 32'(bus2.out_valid), 32'd1);
        check("nom_op7_code", {26'd0, bus2.illegal, bus2.control_out}, 32'h20);
        @(negedge clk);

        // Asynchronous reset in the middle of a DIV
        bus.alu_op = OP_R; bus.fn3 = 3'b100; bus.fn7 = 7'h01; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_busy", 32'(state_dbg), 32'(BUSY));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state_dbg), 32'(IDLE));
        check("arst_ctrl", 32'(bus.control_out), 32'd0);
        check("arst_stall", 32'(bus.stall), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("arst_after_state", 32'(state_dbg), 32'(IDLE));

        check("drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 Parameter CTRL_W, default 5: width of the ALU control code.
REQ-002 Parameter ENABLE_M, default 1: 1 enables RV32M decode; 0 flags all M ops illegal.
REQ-003 Parameter MUL_LAT, default 2, range 1..8: cycles from acceptance to out_valid for MUL/MULH/MULHSU/MULHU.
REQ-004 Parameter DIV_LAT, default 32, range 1..64: cycles from acceptance to out_valid for DIV/DIVU/REM/REMU.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  decode request present.
REQ-009 in_ready  out  1  request can be accepted; equals (state != BUSY).
REQ-010 alu_op  in  3  class: 000 R, 001 I, 010 load, 011 store, 100 branch, 101 jump.
REQ-011 fn3  in  3  funct3.
REQ-012 fn7  in  7  funct7 (R-type) or imm[11:5] (I-type).
REQ-013 flush  in  1  abort the current operation.
REQ-014 control_out  out  CTRL_W  registered ALU control code.
REQ-015 m_start  out  1  one-cycle pulse launching the multi-cycle M unit.
REQ-016 stall  out  1  pipeline hold; high while state is BUSY.
REQ-017 out_valid  out  1  one-cycle pulse: control_out result is complete.
REQ-018 illegal  out  1  registered with control_out; decoded op unsupported.

Function
REQ-019 Codes SHALL be: ADD 00000, SUB 00001, XOR 00010, OR 00011, AND 00100, SLL 00101, SRL 00110, SRA 00111, SLT 01000, SLTU 01001, MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
REQ-020 R-type: fn7=0000000 selects base op by fn3; fn7=0100000 with fn3 000/101 selects SUB/SRA; fn7=0000001 with ENABLE_M=1 selects M op fn3 000..111 in listed order.
REQ-021 I-type: fn3 selects base op (no SUB); fn3=101 selects SRA when fn7=0100000, else SRL.
REQ-022 Load, store, jump SHALL produce ADD regardless of fn3.
REQ-023 Branch: fn3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> ADD with illegal=1.
REQ-024 Any other alu_op or unlisted fn7 pattern SHALL produce ADD with illegal=1 and 1-cycle latency.
REQ-025 Acceptance occurs in a cycle with in_valid=1, in_ready=1, flush=0; control_out/illegal load on that edge.
REQ-026 FSM states IDLE, BUSY, DONE; down-counter width clog2(DIV_LAT+1).
REQ-027 Accepted non-M op (or any op with LAT=1): next state DONE; out_valid=1 one cycle later.
REQ-028 Accepted M op with LAT>1: next state BUSY, counter=LAT-1, m_start=1 for the first BUSY cycle only.
REQ-029 In BUSY: counter decrements each cycle; when counter==1, next state DONE; out_valid therefore appears exactly LAT cycles after acceptance.
REQ-030 M op with LAT=1: m_start pulses in the DONE cycle.
REQ-031 DONE: out_valid=1; new acceptance permitted (back-to-back), else next state IDLE.
REQ-032 in_valid during BUSY SHALL be ignored without side effects.
REQ-033 flush SHALL force IDLE next cycle from any state, suppress out_valid and m_start in that next cycle; flush wins over simultaneous in_valid.
REQ-034 control_out SHALL hold its value until the next acceptance.

Reset
REQ-035 rst_n low SHALL asynchronously set state IDLE, counter 0, control_out 00000 (ADD), illegal 0, m_start 0, out_valid 0, stall 0; in_ready 1 after release.
REQ-036 Reset mid-BUSY SHALL discard the operation; no out_valid after release.

Structure
REQ-037 Control codes, alu_op class values and state enum SHALL live in shared package alu_ctrl_pkg.
REQ-038 Pure combinational decode SHALL be sub-module alu_decode; alu_control_seq holds FSM, counter, registers.

Verification
REQ-039 R ADD/SUB/SRA (alu_op=000, fn3 000/000/101, fn7 00/20/20) -> control_out 00000/00001/00111, out_valid 1 cycle after each acceptance, stall never high.
REQ-040 DIV (alu_op=000, fn7=01, fn3=100), DIV_LAT=32 -> control_out 10100, m_start at T+1, stall T+1..T+31, out_valid at T+32, in_ready=0 throughout BUSY.
REQ-041 MUL with MUL_LAT=2 followed by back-to-back XOR accepted in DONE -> out_valid at T+2 and T+3, codes 10000 then 00010.
REQ-042 flush at T+5 of DIV -> state IDLE at T+6, no out_valid, in_ready=1 at T+6.
REQ-043 ENABLE_M=0, fn7=01 fn3=000 -> control_out 00000, illegal=1, latency 1; alu_op=111 -> same.
REQ-044 rst_n low mid-DIV -> all outputs reset immediately (asynchronous), no out_valid after release.
